// File: rtl/flip_mem_pkg.sv
// Shared types for the flip-datapath memory responder.
package flip_mem_pkg;

  localparam int RD_LAT_MAX = 2;

  typedef enum logic {
    OWNER_ENGINE = 1'b0,
    OWNER_HOST   = 1'b1
  } owner_t;

  // Control part of a read-pipeline slot; the data field is sized by the user.
  typedef struct packed {
    logic   valid;
    owner_t owner;
  } slot_tag_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Fixed-latency read pipeline: RD_LAT registered slots of {tag, data}.
module mem_rd_pipe
  import flip_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  slot_tag_t             in_tag,
  input  logic [DATA_WIDTH-1:0] in_data,
  output slot_tag_t             out_tag,
  output logic [DATA_WIDTH-1:0] out_data
);

  typedef struct packed {
    slot_tag_t             tag;
    logic [DATA_WIDTH-1:0] data;
  } slot_t;

  for (genvar g = 0; g < RD_LAT; g++) begin : g_stage
    slot_t q;
    slot_t d;

    if (g == 0) begin : g_head
      assign d = '{tag: in_tag, data: in_data};
    end else begin : g_body
      assign d = g_stage[g-1].q;
    end

    // Shift one slot per cycle; only the valid bit needs a defined reset value
    always_ff @(posedge clk) begin
      if (reset) begin
        q.tag.valid <= 1'b0;
      end else begin
        q <= d;
      end
    end
  end

  assign out_tag  = g_stage[RD_LAT-1].q.tag;
  assign out_data = g_stage[RD_LAT-1].q.data;

endmodule

// File: rtl/flip_mem_responder.sv
// Single-port BRAM model serving the flip engine, with a lower-priority
// host port for preload and readback. Engine wins every cycle it asks.
module flip_mem_responder
  import flip_mem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bram_en,
  input  logic                  bram_we,
  input  logic [ADDR_W-1:0]     bram_addr,
  input  logic [DATA_WIDTH-1:0] bram_din,
  output logic [DATA_WIDTH-1:0] bram_dout,
  input  logic                  host_req_valid,
  output logic                  host_req_ready,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rsp_valid,
  output logic [DATA_WIDTH-1:0] host_rdata
);

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $fatal(1, "flip_mem_responder: RD_LAT must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

  logic                  host_fire;
  logic [ADDR_W-1:0]     sel_addr;
  logic                  sel_write;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [DATA_WIDTH-1:0] rd_data;
  slot_tag_t             in_tag;
  slot_tag_t             out_tag;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  eng_exit;
  logic                  host_exit;
  logic [DATA_WIDTH-1:0] dout_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  assign host_req_ready = !reset && !bram_en;
  assign host_fire      = host_req_valid && host_req_ready;

  // Pick the single access for this cycle; reset suppresses both write and response
  always_comb begin
    sel_addr     = host_addr;
    sel_wdata    = host_wdata;
    sel_write    = host_fire && host_we;
    in_tag.valid = host_fire && !host_we;
    in_tag.owner = OWNER_HOST;
    if (bram_en) begin
      sel_addr     = bram_addr;
      sel_wdata    = bram_din;
      sel_write    = bram_we;
      in_tag.valid = 1'b1;
      in_tag.owner = OWNER_ENGINE;
    end
    if (reset) begin
      sel_write    = 1'b0;
      in_tag.valid = 1'b0;
    end
  end

  // Read is taken before the edge commits the write, giving read-first behaviour
  assign rd_data = mem[sel_addr];

  // Array write port; contents deliberately not reset
  always_ff @(posedge clk) begin
    if (sel_write) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  mem_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LAT     (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_tag   (in_tag),
    .in_data  (rd_data),
    .out_tag  (out_tag),
    .out_data (out_data)
  );

  assign eng_exit  = out_tag.valid && (out_tag.owner == OWNER_ENGINE);
  assign host_exit = out_tag.valid && (out_tag.owner == OWNER_HOST);

  // Hold the last delivered word per owner once its slot has left the pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (eng_exit) dout_q <= out_data;
      if (host_exit) rdata_q <= out_data;
    end
  end

  // Exiting slot is shown directly so delivery lands RD_LAT edges after issue
  assign bram_dout      = reset ? '0 : (eng_exit ? out_data : dout_q);
  assign host_rdata     = reset ? '0 : (host_exit ? out_data : rdata_q);
  assign host_rsp_valid = !reset && host_exit;

endmodule

// File: tb/tb_flip_mem_responder.sv
// Randomized bench for flip_mem_responder, RD_LAT=1 and RD_LAT=2 side by side,
// checked every cycle against a queue-based response model.
module tb_flip_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       bram_en, bram_we;
  logic [7:0] bram_addr, bram_din;
  logic       host_req_valid, host_we;
  logic [7:0] host_addr, host_wdata;

  logic [7:0] dout_l1, rdata_l1, dout_l2, rdata_l2;
  logic       ready_l1, rsp_l1, ready_l2, rsp_l2;

  always #5 clk = ~clk;

  flip_mem_responder #(.ADDR_W(8), .DATA_WIDTH(8), .RD_LAT(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(dout_l1),
    .host_req_valid(host_req_valid), .host_req_ready(ready_l1),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsp_valid(rsp_l1), .host_rdata(rdata_l1)
  );

  flip_mem_responder #(.ADDR_W(8), .DATA_WIDTH(8), .RD_LAT(2)) u_dut_lat2 (
    .clk(clk), .reset(reset), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .bram_dout(dout_l2),
    .host_req_valid(host_req_valid), .host_req_ready(ready_l2),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rsp_valid(rsp_l2), .host_rdata(rdata_l2)
  );

  // Reference model: memory image plus, per DUT, a queue of responses due at a cycle
  typedef struct {
    int         due;
    bit         host;
    logic [7:0] data;
  } rsp_t;

  logic [7:0] mem_m [256];
  rsp_t       q_l1 [$];
  rsp_t       q_l2 [$];
  logic [7:0] exp_dout  [2];
  logic [7:0] exp_rdata [2];
  bit         exp_rsp   [2];
  bit         host_acc;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         pulse_cnt [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic deliver(input int d, input rsp_t it);
    if (it.host) begin
      exp_rsp[d]   = 1'b1;
      exp_rdata[d] = it.data;
    end else begin
      exp_dout[d] = it.data;
    end
  endtask

  task automatic push_rsp(input bit host, input logic [7:0] data);
    rsp_t it;
    it.host = host;
    it.data = data;
    it.due  = cyc;
    q_l1.push_back(it);
    it.due  = cyc + 1;
    q_l2.push_back(it);
  endtask

  // Apply the inputs seen at this edge to the model
  task automatic model_edge();
    rsp_t it;
    cyc++;
    host_acc   = 1'b0;
    exp_rsp[0] = 1'b0;
    exp_rsp[1] = 1'b0;
    if (reset) begin
      q_l1.delete();
      q_l2.delete();
      for (int d = 0; d < 2; d++) begin
        exp_dout[d]  = '0;
        exp_rdata[d] = '0;
      end
    end else begin
      if (bram_en) begin
        push_rsp(1'b0, mem_m[bram_addr]);
        if (bram_we) mem_m[bram_addr] = bram_din;
      end else if (host_req_valid) begin
        host_acc = 1'b1;
        if (host_we) mem_m[host_addr] = host_wdata;
        else push_rsp(1'b1, mem_m[host_addr]);
      end
      if (q_l1.size() > 0 && q_l1[0].due == cyc) begin
        it = q_l1.pop_front();
        deliver(0, it);
      end
      if (q_l2.size() > 0 && q_l2[0].due == cyc) begin
        it = q_l2.pop_front();
        deliver(1, it);
      end
    end
  endtask

  task automatic check_dut(input int d, input logic rdy, input logic rsp,
                           input logic [7:0] dout, input logic [7:0] rdata);
    string p;
    p = $sformatf("lat%0d.", d + 1);
    check_eq({p, "host_req_ready"}, 32'(rdy), 32'(!reset && !bram_en));
    check_eq({p, "host_rsp_valid"}, 32'(rsp), 32'(!reset && exp_rsp[d]));
    check_eq({p, "bram_dout"}, 32'(dout), reset ? 32'd0 : 32'(exp_dout[d]));
    check_eq({p, "host_rdata"}, 32'(rdata), reset ? 32'd0 : 32'(exp_rdata[d]));
    if (rsp === 1'b1) pulse_cnt[d]++;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_dut(0, ready_l1, rsp_l1, dout_l1, rdata_l1);
    check_dut(1, ready_l2, rsp_l2, dout_l2, rdata_l2);
  endtask

  task automatic drive(input bit en, input bit we, input logic [7:0] a, input logic [7:0] di,
                       input bit hv, input bit hwe, input logic [7:0] ha, input logic [7:0] hd,
                       input bit rst);
    bram_en        = en;
    bram_we        = we;
    bram_addr      = a;
    bram_din       = di;
    host_req_valid = hv;
    host_we        = hwe;
    host_addr      = ha;
    host_wdata     = hd;
    reset          = rst;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);
  endtask

  initial begin
    bit         h_pend;
    bit         h_we;
    logic [7:0] h_addr, h_wd;
    logic [7:0] a;

    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    for (int d = 0; d < 2; d++) begin
      exp_dout[d]  = '0;
      exp_rdata[d] = '0;
      exp_rsp[d]   = 1'b0;
    end

    // Reset for a few cycles with an engine request present: everything must read 0
    for (int i = 0; i < 3; i++) drive(1, 1, 8'h55, 8'hFF, 1, 1, 8'h55, 8'hEE, 1);

    // Preload the whole array through the host; 0x10..0x1F get 0x00..0x0F
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      drive(0, 0, 8'h00, 8'h00, 1, 1, a,
            (i >= 16 && i < 32) ? 8'(i - 16) : 8'($urandom), 0);
    end

    // Back-to-back host readback of 0x10..0x1F: 16 pulses per DUT
    pulse_cnt[0] = 0;
    pulse_cnt[1] = 0;
    for (int i = 0; i < 16; i++) drive(0, 0, 8'h00, 8'h00, 1, 0, 8'(8'h10 + i), 8'h00, 0);
    idle(3);
    check_eq("lat1.readback_pulses", 32'(pulse_cnt[0]), 32'd16);
    check_eq("lat2.readback_pulses", 32'(pulse_cnt[1]), 32'd16);

    // Engine write 0xA5 to 0x20 then read it back next cycle
    drive(1, 1, 8'h20, 8'hA5, 0, 0, 8'h00, 8'h00, 0);
    drive(1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00, 0);
    idle(2);
    check_eq("lat1.engine_wr_rd", 32'(dout_l1), 32'hA5);
    check_eq("lat2.engine_wr_rd", 32'(dout_l2), 32'hA5);

    // Engine busy 5 cycles while the host waits to read 0x10
    for (int i = 0; i < 5; i++) drive(1, 0, 8'(8'h30 + i), 8'h00, 1, 0, 8'h10, 8'h00, 0);
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h00, 0);
    check_eq("host_accept_after_stall", 32'(host_acc), 32'd1);
    idle(3);
    check_eq("lat2.stalled_read_data", 32'(rdata_l2), 32'h00);

    // Interleaved engine 0x11 / host 0x12
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 8'h11, 8'h00, 0, 0, 8'h00, 8'h00, 0);
      drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h12, 8'h00, 0);
    end
    idle(3);
    check_eq("lat2.interleave_dout", 32'(dout_l2), 32'h01);
    check_eq("lat2.interleave_rdata", 32'(rdata_l2), 32'h02);

    // Host read in flight when reset hits: no pulse, array kept
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h13, 8'h00, 0);
    drive(1, 1, 8'h13, 8'h77, 0, 0, 8'h00, 8'h00, 1);
    idle(3);
    drive(0, 0, 8'h00, 8'h00, 1, 0, 8'h13, 8'h00, 0);
    idle(3);
    check_eq("lat1.post_reset_read", 32'(rdata_l1), 32'h03);

    // Random mix with address hazards and occasional reset; host holds until accepted
    h_pend = 1'b0;
    h_we   = 1'b0;
    h_addr = '0;
    h_wd   = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!h_pend && $urandom_range(0, 1) == 1) begin
        h_pend = 1'b1;
        h_we   = ($urandom_range(0, 2) == 0);
        h_addr = 8'(8'h40 + $urandom_range(0, 7));
        h_wd   = 8'($urandom);
      end
      drive(($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
            8'(8'h40 + $urandom_range(0, 7)), 8'($urandom),
            h_pend, h_we, h_addr, h_wd, ($urandom_range(0, 99) == 0));
      if (host_acc) h_pend = 1'b0;
    end
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
